// File: rtl/nts_noncegen_arbiter.sv
// nts_noncegen_arbiter: rate-limited sequential nonce prefetch buffer shared round-robin among engines
module nts_noncegen_arbiter #(
  parameter int ENGINES = 4,
  parameter int NONCE_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int DELAY = 15,
  parameter logic [NONCE_WIDTH-1:0] SEED = '0
) (
  input  logic                       i_clk,
  input  logic                       i_areset_n,
  input  logic                       i_enable,
  input  logic [ENGINES-1:0]         i_get,
  output logic [ENGINES-1:0]         o_ready,
  output logic [NONCE_WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [ENGINES-1:0]         o_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = ENGINES > 1 ? $clog2(ENGINES) : 1;
  localparam int TW = DELAY > 1 ? $clog2(DELAY) : 1;
  logic [NONCE_WIDTH-1:0] mem [DEPTH];
  logic [NONCE_WIDTH-1:0] next_nonce;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [TW-1:0] timer;
  logic [EW-1:0] last_grant, grant, idx;
  logic [ENGINES-1:0] req, grant_oh;
  logic full, push, pop, found;
  assign full = o_level == LW'(DEPTH);
  assign req = o_pending | i_get;
  assign push = i_enable && !full && timer == TW'(DELAY - 1);
  assign pop = o_level != '0 && req != '0;
  assign grant_oh = ENGINES'(1) << grant;
  // round-robin search starting just after the last granted engine
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= ENGINES; k++) begin
      idx = EW'((int'(last_grant) + k) % ENGINES);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  // generation timer: parked at zero while full, frozen while disabled
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) timer <= '0;
    else if (full) timer <= '0;
    else if (i_enable) timer <= push ? '0 : timer + 1'b1;
  end
  // nonce storage, written at the tail on each push
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= next_nonce;
  end
  // buffer pointers, level, pending requests and registered grant outputs
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      next_nonce <= SEED;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_grant <= EW'(ENGINES - 1);
      o_ready <= '0;
      o_data <= '0;
      o_level <= '0;
      o_pending <= '0;
    end else begin
      if (push) begin
        next_nonce <= next_nonce + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_grant <= grant;
        o_data <= mem[rd_ptr];
      end
      o_ready <= pop ? grant_oh : '0;
      o_pending <= req & ~(pop ? grant_oh : '0);
      o_level <= o_level + LW'(push) - LW'(pop);
    end
  end
endmodule
